top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter LINES, default 8: number of display lines written per frame (1..1023).
REQ-002 SHALL have parameter PIXELS, default 336: data bits per line (multiple of 8).
REQ-003 SHALL have port refclk, input, 1 bit: single 12 MHz clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port lcd_sclk, output, 1 bit: memory-LCD serial clock, idle low.
REQ-006 SHALL have port lcd_si, output, 1 bit: memory-LCD serial data.
REQ-007 SHALL have port lcd_scs, output, 1 bit: memory-LCD chip select, active-high.
REQ-008 SHALL have port sim_success, output, 1 bit: frame completed with correct bit count.
REQ-009 SHALL have port sim_done, output, 1 bit: frame transfer finished.
REQ-010 SHALL have port sim_report, output, 32 bits: count of lcd_sclk rising edges in the frame.

Function
REQ-011 SHALL, after reset release, transmit exactly one frame, then idle forever with sim_done high.
REQ-012 SHALL run lcd_sclk at refclk/2: toggle every refclk cycle while shifting; lcd_si changes only while lcd_sclk is low, and is stable across each rising edge.
REQ-013 SHALL assert lcd_scs 4 refclk cycles before the first lcd_sclk rising edge and deassert it 4 cycles after the last falling edge.
REQ-014 SHALL send per line, in order: 6 mode bits M0..M5 = 1,0,0,0,0,0 (update mode, VCOM 0); 10 address bits, LSB first, address = line index + 1; PIXELS data bits; 16 zero trailer bits.
REQ-015 SHALL make data bit for line L, pixel P equal L[0] XOR P[0] (checkerboard), pixel 0 first.
REQ-016 SHALL keep lcd_scs high across all LINES lines of the frame (one continuous multi-line write).
REQ-017 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD, DONE: IDLE->SETUP immediately after reset; SETUP->SHIFT after 4 cycles; SHIFT->HOLD after the last trailer bit of line LINES; HOLD->DONE after 4 cycles; DONE terminal.
REQ-018 SHALL increment a 32-bit counter on every lcd_sclk rising edge and drive it on sim_report continuously.
REQ-019 SHALL, on entering DONE, set sim_done=1 and sim_success=1 iff the counter equals LINES*(32+PIXELS) (default 2944); both hold until reset.
REQ-020 SHALL hold lcd_si low whenever lcd_scs is low.
REQ-021 SHALL complete the default frame in under 6000 refclk cycles plus setup/hold (well under 800 us).

Reset
REQ-022 SHALL, while rst=0 at a clock edge, force FSM to IDLE, lcd_sclk=0, lcd_si=0, lcd_scs=0, sim_done=0, sim_success=0, counter=0.
REQ-023 SHALL, on reset asserted mid-frame, abort immediately (lcd_scs low next cycle) and restart a full frame after release.

Structure
REQ-024 SHALL place FSM state encoding, mode-bit constant, trailer length (16), setup/hold count (4) in a shared package memlcd_pkg.
REQ-025 SHALL implement the serializer (bit/line counters, shift sequencing, sclk generation) as one sub-module memlcd_tx; top holds FSM, counter and sim status.

Verification
REQ-026 SHALL check: reset held 10 cycles then released -> lcd_scs rises, first lcd_sclk rise exactly 4 cycles later, lcd_sclk idle low beforehand.
REQ-027 SHALL check: decode the first 16 bits -> mode 1,0,0,0,0,0 and address 1; line 2 header carries address 2.
REQ-028 SHALL check: sample lcd_si on rising lcd_sclk -> line 0 data 0,1,0,1...; line 1 data 1,0,1,0...; 16 zeros after each line.
REQ-029 SHALL check: end of default frame -> sim_report=2944, sim_success=1, sim_done=1, lcd_scs low, no further lcd_sclk edges.
REQ-030 SHALL check: rst pulsed low mid-line 3 -> lcd_scs low, outputs cleared, fresh frame with address 1 after release.
REQ-031 SHALL check: LINES=1, PIXELS=8 -> sim_report=40, sim_success=1.

Source files
------------

// File: rtl/memlcd_pkg.sv
// Shared constants, FSM encoding and the per-bit frame content function
// for the memory-LCD frame writer.
package memlcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned MODE_LEN     = 6;
  // M0 sits in bit 0: update mode, VCOM 0
  localparam logic [MODE_LEN-1:0] MODE_BITS = 6'b000001;
  localparam int unsigned ADDR_LEN     = 10;
  localparam int unsigned HDR_LEN      = MODE_LEN + ADDR_LEN;
  localparam int unsigned TRAILER_LEN  = 16;
  localparam int unsigned GUARD_CYCLES = 4;

  // Value of bit idx within the given line: mode, LSB-first address (line+1),
  // checkerboard pixels, then zero trailer.
  function automatic logic frame_bit(input int unsigned line,
                                     input int unsigned idx,
                                     input int unsigned pixels);
    logic [ADDR_LEN-1:0] addr;
    logic [2:0]          mi;
    logic [3:0]          ai;
    int unsigned         p;
    addr = ADDR_LEN'(line + 1);
    mi   = idx[2:0];
    ai   = 4'(idx - MODE_LEN);
    p    = idx - HDR_LEN;
    if (idx < MODE_LEN)
      return MODE_BITS[mi];
    else if (idx < HDR_LEN)
      return addr[ai];
    else if (idx < HDR_LEN + pixels)
      return line[0] ^ p[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/memlcd_if.sv
// Control and serial-bus bundle between the frame controller and the serializer.
interface memlcd_if;
    logic arm;
    logic start;
    logic rise;
    logic done;
    logic sclk;
    logic si;

    modport master (output arm, output start, input rise, input done, input sclk, input si);
    modport slave  (input arm, input start, output rise, output done, output sclk, output si);
endinterface

// File: rtl/memlcd_tx.sv
// Serializer: walks bit/line counters, generates sclk at refclk/2 and
// drives si so it only changes while sclk is low.
module memlcd_tx
    import memlcd_pkg::*;
#(
    parameter int unsigned LINES  = 8,
    parameter int unsigned PIXELS = 336
) (
    input  logic     refclk,
    input  logic     rst,
    memlcd_if.slave  bus
);

    localparam int unsigned LINE_BITS = HDR_LEN + PIXELS + TRAILER_LEN;
    localparam int unsigned BIT_W     = $clog2(LINE_BITS);
    localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(LINE_BITS - 1);
    localparam logic [ADDR_LEN-1:0] LAST_LINE = ADDR_LEN'(LINES - 1);

    logic                r_active;
    logic                r_sclk;
    logic                r_si;
    logic [BIT_W-1:0]    r_bit;
    logic [ADDR_LEN-1:0] r_line;

    logic                w_line_end;
    logic                w_last;
    logic [BIT_W-1:0]    w_next_bit;
    logic [ADDR_LEN-1:0] w_next_line;

    assign w_line_end  = (r_bit == LAST_BIT);
    assign w_last      = w_line_end && (r_line == LAST_LINE);
    assign w_next_bit  = w_line_end ? '0 : r_bit + 1'b1;
    assign w_next_line = w_line_end ? r_line + 1'b1 : r_line;

    assign bus.sclk = r_sclk;
    assign bus.si   = r_si;
    // The start edge is itself the first rising edge, so it counts as a rise
    assign bus.rise = r_active ? ~r_sclk : bus.start;
    assign bus.done = r_active & r_sclk & w_last;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_si     <= 1'b0;
            r_bit    <= '0;
            r_line   <= '0;
        end else if (!r_active) begin
            r_bit  <= '0;
            r_line <= '0;
            r_si   <= bus.arm ? frame_bit(0, 0, PIXELS) : 1'b0;
            r_sclk <= 1'b0;
            if (bus.start) begin
                r_active <= 1'b1;
                r_sclk   <= 1'b1;
            end
        end else if (!r_sclk) begin
            r_sclk <= 1'b1;
        end else begin
            r_sclk <= 1'b0;
            if (w_last) begin
                r_active <= 1'b0;
                r_si     <= 1'b0;
                r_bit    <= '0;
                r_line   <= '0;
            end else begin
                r_bit  <= w_next_bit;
                r_line <= w_next_line;
                r_si   <= frame_bit(32'(w_next_line), 32'(w_next_bit), PIXELS);
            end
        end
    end

endmodule

// File: rtl/top.sv
// Memory-LCD single-frame writer: frame FSM with chip-select guard timing,
// sclk rising-edge counter and completion status.
module top
    import memlcd_pkg::*;
#(
    parameter int unsigned LINES  = 8,
    parameter int unsigned PIXELS = 336
) (
    input  logic        refclk,
    input  logic        rst,
    output logic        lcd_sclk,
    output logic        lcd_si,
    output logic        lcd_scs,
    output logic        sim_success,
    output logic        sim_done,
    output logic [31:0] sim_report
);

    localparam logic [31:0] EXPECTED   = 32'(LINES * (32 + PIXELS));
    localparam logic [2:0]  GUARD_LAST = 3'(GUARD_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_count;
    logic        r_scs;
    logic        r_done;
    logic        r_success;

    memlcd_if u_bus ();

    // Start fires on the SETUP->SHIFT edge so the first rise lands there
    assign u_bus.arm   = (r_state == SETUP);
    assign u_bus.start = (r_state == SETUP) && (r_cnt == GUARD_LAST);

    memlcd_tx #(
        .LINES  (LINES),
        .PIXELS (PIXELS)
    ) u_tx (
        .refclk (refclk),
        .rst    (rst),
        .bus    (u_bus.slave)
    );

    assign lcd_sclk    = u_bus.sclk;
    assign lcd_si      = u_bus.si;
    assign lcd_scs     = r_scs;
    assign sim_done    = r_done;
    assign sim_success = r_success;
    assign sim_report  = r_count;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_count   <= '0;
            r_scs     <= 1'b0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
        end else begin
            if (u_bus.rise)
                r_count <= r_count + 1'b1;
            case (r_state)
                IDLE: begin
                    r_state <= SETUP;
                    r_scs   <= 1'b1;
                    r_cnt   <= '0;
                end
                SETUP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == GUARD_LAST)
                        r_state <= SHIFT;
                end
                SHIFT: begin
                    if (u_bus.done) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == GUARD_LAST) begin
                        r_state   <= DONE;
                        r_scs     <= 1'b0;
                        r_done    <= 1'b1;
                        r_success <= (r_count == EXPECTED);
                    end
                end
                DONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: expected serial bits are queued per frame and a
// negedge monitor pops one per observed lcd_sclk rising edge.
module tb_top;

    localparam int unsigned PIX = 336;
    localparam int unsigned LN  = 8;
    localparam int unsigned LINE_LEN = 32 + PIX;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic        lcd_sclk, lcd_si, lcd_scs, sim_success, sim_done;
    logic [31:0] sim_report;
    logic        lcd_sclk2, lcd_si2, lcd_scs2, sim_success2, sim_done2;
    logic [31:0] sim_report2;

    always #5 clk = ~clk;

    top #(.LINES(LN), .PIXELS(PIX)) dut (
        .refclk(clk), .rst(rst_n), .lcd_sclk(lcd_sclk), .lcd_si(lcd_si),
        .lcd_scs(lcd_scs), .sim_success(sim_success), .sim_done(sim_done),
        .sim_report(sim_report)
    );

    top #(.LINES(1), .PIXELS(8)) dut_small (
        .refclk(clk), .rst(rst2_n), .lcd_sclk(lcd_sclk2), .lcd_si(lcd_si2),
        .lcd_scs(lcd_scs2), .sim_success(sim_success2), .sim_done(sim_done2),
        .sim_report(sim_report2)
    );

    memlcd_if mon ();
    assign mon.sclk  = lcd_sclk;
    assign mon.si    = lcd_si;
    assign mon.arm   = lcd_scs;
    assign mon.done  = sim_done;
    assign mon.start = 1'b0;
    assign mon.rise  = 1'b0;

    typedef struct {
        logic        b;
        int unsigned line;
        int unsigned idx;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   rises = 0;
    logic prev_sclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string field(input int unsigned idx);
        if (idx < 6)              return "mode";
        else if (idx < 16)        return "addr";
        else if (idx < 16 + PIX)  return "data";
        else                      return "trailer";
    endfunction

    task automatic push_frame();
        logic [5:0] mode;
        logic [9:0] addr;
        exp_t e;
        mode = 6'b000001;
        for (int unsigned l = 0; l < LN; l++) begin
            addr = 10'(l + 1);
            for (int unsigned i = 0; i < LINE_LEN; i++) begin
                e.line = l;
                e.idx  = i;
                if (i < 6)              e.b = mode[i];
                else if (i < 16)        e.b = addr[i-6];
                else if (i < 16 + PIX)  e.b = ((l % 2) != ((i - 16) % 2));
                else                    e.b = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    // Monitor: one expected bit consumed per lcd_sclk rising edge
    always @(negedge clk) begin
        exp_t e;
        if (mon.sclk && !prev_sclk) begin
            rises++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_sclk_rise: got rise #%0d expected none", rises);
            end else begin
                e = q.pop_front();
                check($sformatf("%s_L%0d_b%0d", field(e.idx), e.line, e.idx), 32'(mon.si), 32'(e.b));
            end
        end
        prev_sclk = mon.sclk;
    end

    initial begin
        int a, b, early, waited;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_scs", 32'(lcd_scs), 0);
        check("rst_sclk", 32'(lcd_sclk), 0);
        check("rst_si", 32'(lcd_si), 0);
        check("rst_done", 32'(sim_done), 0);
        check("rst_success", 32'(sim_success), 0);
        check("rst_report", sim_report, 0);

        push_frame();
        rst_n = 1'b1;
        a = -100; b = -1; early = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lcd_scs && a < 0) a = k;
            if (lcd_sclk && b < 0) b = k;
            if (b < 0 && lcd_sclk) early++;
            if (a < 0 && lcd_sclk) early++;
        end
        check("scs_to_first_rise", 32'(b - a), 4);
        check("sclk_idle_before_scs", 32'(early), 0);

        // Run into line 3, then pulse reset mid-line
        waited = 0;
        while (rises < int'(3 * LINE_LEN + 50) && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        check("reach_line3_timeout", 32'(waited < 10000), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        push_frame();
        rises = 0;
        @(negedge clk);
        check("abort_scs", 32'(lcd_scs), 0);
        check("abort_sclk", 32'(lcd_sclk), 0);
        check("abort_si", 32'(lcd_si), 0);
        check("abort_report", sim_report, 0);
        check("abort_done", 32'(sim_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        waited = 0;
        while (!sim_done && waited < 8000) begin
            @(negedge clk);
            waited++;
        end
        check("frame_done_timeout", 32'(waited < 8000), 1);
        check("end_report", sim_report, 2944);
        check("end_success", 32'(sim_success), 1);
        check("end_done", 32'(sim_done), 1);
        check("end_scs", 32'(lcd_scs), 0);
        check("end_si", 32'(lcd_si), 0);
        check("end_rise_count", 32'(rises), 2944);
        check("end_queue_left", 32'(q.size()), 0);
        repeat (40) @(negedge clk);
        check("idle_no_rises", 32'(rises), 2944);
        check("idle_report", sim_report, 2944);
        check("idle_done", 32'(sim_done), 1);

        rst2_n = 1'b1;
        waited = 0;
        while (!sim_done2 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("small_done_timeout", 32'(waited < 300), 1);
        check("small_report", sim_report2, 40);
        check("small_success", 32'(sim_success2), 1);
        check("small_done", 32'(sim_done2), 1);
        check("small_scs", 32'(lcd_scs2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
